// File: rtl/eightbit_pkg.sv
// Shared definitions for the four-stage pipeline controller: stage-state encodings,
// instruction step size, register-index width and opcode constants.
package eightbit_pkg;

    // A stage's state is the pair {en, ready}.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RESETTING = 2'b01,
        ST_BUSY      = 2'b10,
        ST_COMPLETE  = 2'b11
    } stage_st_e;

    localparam int unsigned PC_STEP_BYTES = 2;
    localparam int unsigned REG_IDX_W     = 4;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_ALU    = 4'h1,
        OP_LOAD   = 4'h2,
        OP_STORE  = 4'h3,
        OP_BRANCH = 4'h4,
        OP_JUMP   = 4'h5
    } opcode_e;

    function automatic stage_st_e stage_of(input logic en, input logic ready);
        return stage_st_e'({en, ready});
    endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Pending-write tracker: one bit per register, set when a writer enters exec,
// cleared when it retires or is flushed; two read ports feed the hazard check.
module scoreboard #(
    parameter int unsigned REG_CNT = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic [IDX_W-1:0] rd0_idx,
    input  logic [IDX_W-1:0] rd1_idx,
    output logic             rd0_pend,
    output logic             rd1_pend
);

    logic [REG_CNT-1:0] sb_q;
    logic [REG_CNT-1:0] sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_idx] = 1'b0;
        end
        // Applied after the clear so a new writer keeps its bit when an older one retires.
        if (set_en) begin
            sb_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign rd0_pend = sb_q[rd0_idx];
    assign rd1_pend = sb_q[rd1_idx];

endmodule

// File: rtl/pipe_ctrl.sv
// Four-stage pipeline controller: registered stage enables, handoff strobes,
// fetch PC, RAW hazard stall via the scoreboard, and exec-driven redirect.
module pipe_ctrl
    import eightbit_pkg::*;
#(
    parameter int unsigned PC_W    = 8,
    parameter int unsigned REG_CNT = 16,
    parameter int unsigned PC_STEP = PC_STEP_BYTES
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_ready,
    input  logic                 decode_ready,
    input  logic                 exec_ready,
    input  logic                 wb_ready,
    output logic                 fetch_en,
    output logic                 decode_en,
    output logic                 exec_en,
    output logic                 wb_en,
    input  logic [REG_IDX_W-1:0] dec_rd,
    input  logic [REG_IDX_W-1:0] dec_rs0,
    input  logic [REG_IDX_W-1:0] dec_rs1,
    input  logic                 dec_writes,
    input  logic [1:0]           dec_reads,
    input  logic                 exec_flush,
    input  logic [PC_W-1:0]      exec_pc,
    output logic [PC_W-1:0]      pc,
    output logic                 ld_decode,
    output logic                 ld_exec,
    output logic                 ld_wb,
    output logic                 hazard
);

    logic [PC_W-1:0]      pc_q, pc_d;
    logic                 fetch_en_q, fetch_en_d;
    logic                 decode_en_q, decode_en_d;
    logic                 exec_en_q, exec_en_d;
    logic                 wb_en_q, wb_en_d;
    logic [REG_IDX_W-1:0] exec_rd_q, exec_rd_d;
    logic                 exec_wr_q, exec_wr_d;
    logic [REG_IDX_W-1:0] wb_rd_q, wb_rd_d;
    logic                 wb_wr_q, wb_wr_d;

    stage_st_e fetch_st, decode_st, exec_st, wb_st;
    logic      fetch_go, decode_go, exec_go, wb_done, flush;
    logic      rs0_pend, rs1_pend;
    logic      sb_set, sb_clr;
    logic [REG_IDX_W-1:0] sb_clr_idx;

    assign fetch_st  = stage_of(fetch_en_q, fetch_ready);
    assign decode_st = stage_of(decode_en_q, decode_ready);
    assign exec_st   = stage_of(exec_en_q, exec_ready);
    assign wb_st     = stage_of(wb_en_q, wb_ready);

    always_comb begin
        hazard    = (decode_st == ST_COMPLETE) &&
                    ((dec_reads[0] && rs0_pend) || (dec_reads[1] && rs1_pend));
        exec_go   = (exec_st == ST_COMPLETE) && (wb_st == ST_IDLE || wb_st == ST_RESETTING);
        flush     = exec_go && exec_flush;
        decode_go = (decode_st == ST_COMPLETE) && (exec_st == ST_IDLE || exec_st == ST_RESETTING)
                    && !hazard && !flush;
        fetch_go  = (fetch_st == ST_COMPLETE) && (decode_st == ST_IDLE) && !flush;
        wb_done   = (wb_st == ST_COMPLETE);
    end

    // Retire and flush clears are mutually exclusive: a flush needs wb free, a retire needs wb busy.
    assign sb_set     = decode_go && dec_writes;
    assign sb_clr     = (flush && exec_wr_q) || (wb_done && wb_wr_q);
    assign sb_clr_idx = flush ? exec_rd_q : wb_rd_q;

    always_comb begin
        pc_d        = pc_q;
        fetch_en_d  = fetch_en_q;
        decode_en_d = decode_en_q;
        exec_en_d   = exec_en_q;
        wb_en_d     = wb_en_q;
        exec_rd_d   = exec_rd_q;
        exec_wr_d   = exec_wr_q;
        wb_rd_d     = wb_rd_q;
        wb_wr_d     = wb_wr_q;
        if (fetch_st == ST_IDLE) begin
            fetch_en_d = 1'b1;
        end
        if (fetch_go) begin
            fetch_en_d  = 1'b0;
            decode_en_d = 1'b1;
            pc_d        = pc_q + PC_W'(PC_STEP);
        end
        if (decode_go) begin
            decode_en_d = 1'b0;
            exec_en_d   = 1'b1;
            exec_rd_d   = dec_rd;
            exec_wr_d   = dec_writes;
        end
        if (exec_go) begin
            exec_en_d = 1'b0;
            wb_en_d   = !exec_flush;
            wb_rd_d   = exec_rd_q;
            wb_wr_d   = exec_wr_q && !exec_flush;
        end
        if (wb_done) begin
            wb_en_d = 1'b0;
        end
        if (flush) begin
            pc_d        = exec_pc;
            fetch_en_d  = 1'b0;
            decode_en_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q        <= '0;
            fetch_en_q  <= 1'b0;
            decode_en_q <= 1'b0;
            exec_en_q   <= 1'b0;
            wb_en_q     <= 1'b0;
            exec_rd_q   <= '0;
            exec_wr_q   <= 1'b0;
            wb_rd_q     <= '0;
            wb_wr_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            fetch_en_q  <= fetch_en_d;
            decode_en_q <= decode_en_d;
            exec_en_q   <= exec_en_d;
            wb_en_q     <= wb_en_d;
            exec_rd_q   <= exec_rd_d;
            exec_wr_q   <= exec_wr_d;
            wb_rd_q     <= wb_rd_d;
            wb_wr_q     <= wb_wr_d;
        end
    end

    scoreboard #(
        .REG_CNT (REG_CNT),
        .IDX_W   (REG_IDX_W)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (sb_set),
        .set_idx  (dec_rd),
        .clr_en   (sb_clr),
        .clr_idx  (sb_clr_idx),
        .rd0_idx  (dec_rs0),
        .rd1_idx  (dec_rs1),
        .rd0_pend (rs0_pend),
        .rd1_pend (rs1_pend)
    );

    assign pc        = pc_q;
    assign fetch_en  = fetch_en_q;
    assign decode_en = decode_en_q;
    assign exec_en   = exec_en_q;
    assign wb_en     = wb_en_q;
    assign ld_decode = fetch_go;
    assign ld_exec   = decode_go;
    assign ld_wb     = exec_go;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random traffic, checked against an
// instruction-occupancy model with a pending-register set.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       fetch_ready, decode_ready, exec_ready, wb_ready;
    logic       fetch_en, decode_en, exec_en, wb_en;
    logic [3:0] dec_rd, dec_rs0, dec_rs1;
    logic       dec_writes;
    logic [1:0] dec_reads;
    logic       exec_flush;
    logic [7:0] exec_pc;
    logic [7:0] pc;
    logic       ld_decode, ld_exec, ld_wb, hazard;

    always #5 clk = ~clk;

    pipe_ctrl #(.PC_W(8), .REG_CNT(16), .PC_STEP(2)) dut (
        .clk(clk), .rst(rst),
        .fetch_ready(fetch_ready), .decode_ready(decode_ready),
        .exec_ready(exec_ready), .wb_ready(wb_ready),
        .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
        .dec_rd(dec_rd), .dec_rs0(dec_rs0), .dec_rs1(dec_rs1),
        .dec_writes(dec_writes), .dec_reads(dec_reads),
        .exec_flush(exec_flush), .exec_pc(exec_pc),
        .pc(pc), .ld_decode(ld_decode), .ld_exec(ld_exec), .ld_wb(ld_wb), .hazard(hazard)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] rd;
        logic [3:0] rs0;
        logic       writes;
        logic [1:0] reads;
    } instr_t;

    instr_t prog[$];
    int     n_exec;

    // Model: which stages hold an instruction (0 fetch, 1 decode, 2 exec, 3 wb)
    bit         m_occ[4];
    int         m_pc;
    logic [3:0] m_ex_rd, m_wb_rd;
    bit         m_ex_wr, m_wb_wr;
    bit         m_pend[16];
    bit         p_ld_dec, p_ld_exec, p_ld_wb, p_haz, p_flush;
    int         ages[4];
    int         dly[4];

    logic       last_ld_decode, last_ld_exec;
    int         haz_cnt;
    logic [7:0] pc_log[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk(input int rd, input int rs0, input bit wr, input int rds);
        instr_t i;
        i.rd     = 4'(rd);
        i.rs0    = 4'(rs0);
        i.writes = wr;
        i.reads  = 2'(rds);
        return i;
    endfunction

    task automatic model_reset();
        foreach (m_occ[i]) m_occ[i] = 1'b0;
        foreach (m_pend[i]) m_pend[i] = 1'b0;
        foreach (ages[i]) ages[i] = 0;
        m_pc = 0;
        m_ex_rd = '0; m_wb_rd = '0; m_ex_wr = 1'b0; m_wb_wr = 1'b0;
    endtask

    task automatic model_eval();
        bit rdy[4];
        rdy[0] = fetch_ready; rdy[1] = decode_ready; rdy[2] = exec_ready; rdy[3] = wb_ready;
        p_haz = 1'b0; p_ld_wb = 1'b0; p_flush = 1'b0; p_ld_exec = 1'b0; p_ld_dec = 1'b0;
        if (rst) begin
            p_haz     = m_occ[1] && rdy[1] &&
                        ((dec_reads[0] && m_pend[dec_rs0]) || (dec_reads[1] && m_pend[dec_rs1]));
            p_ld_wb   = m_occ[2] && rdy[2] && !m_occ[3];
            p_flush   = p_ld_wb && exec_flush;
            p_ld_exec = m_occ[1] && rdy[1] && !m_occ[2] && !p_haz && !p_flush;
            p_ld_dec  = m_occ[0] && rdy[0] && !m_occ[1] && !rdy[1] && !p_flush;
        end
    endtask

    task automatic model_commit();
        bit rdy[4];
        bit nocc[4];
        rdy[0] = fetch_ready; rdy[1] = decode_ready; rdy[2] = exec_ready; rdy[3] = wb_ready;
        if (!rst) begin
            model_reset();
            return;
        end
        nocc = m_occ;
        if (m_occ[3] && rdy[3]) begin
            nocc[3] = 1'b0;
            if (m_wb_wr) m_pend[m_wb_rd] = 1'b0;
        end
        if (p_ld_wb) begin
            nocc[2] = 1'b0;
            nocc[3] = !p_flush;
            m_wb_rd = m_ex_rd;
            m_wb_wr = m_ex_wr && !p_flush;
            if (p_flush && m_ex_wr) m_pend[m_ex_rd] = 1'b0;
        end
        if (p_ld_exec) begin
            nocc[1] = 1'b0;
            nocc[2] = 1'b1;
            m_ex_rd = dec_rd;
            m_ex_wr = dec_writes;
            if (dec_writes) m_pend[dec_rd] = 1'b1;
            n_exec++;
        end
        if (p_ld_dec) begin
            nocc[0] = 1'b0;
            nocc[1] = 1'b1;
            m_pc = (m_pc + 2) % 256;
        end
        if (!m_occ[0] && !rdy[0] && !p_flush) nocc[0] = 1'b1;
        if (p_flush) begin
            m_pc = int'(exec_pc);
            nocc[0] = 1'b0;
            nocc[1] = 1'b0;
        end
        for (int i = 0; i < 4; i++) ages[i] = (nocc[i] && m_occ[i]) ? ages[i] + 1 : 0;
        m_occ = nocc;
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic tick();
        #3;
        model_eval();
        check("pc", pc, m_pc[7:0]);
        check1("fetch_en", fetch_en, m_occ[0]);
        check1("decode_en", decode_en, m_occ[1]);
        check1("exec_en", exec_en, m_occ[2]);
        check1("wb_en", wb_en, m_occ[3]);
        check1("ld_decode", ld_decode, p_ld_dec);
        check1("ld_exec", ld_exec, p_ld_exec);
        check1("ld_wb", ld_wb, p_ld_wb);
        check1("hazard", hazard, p_haz);
        last_ld_decode = ld_decode;
        last_ld_exec   = ld_exec;
        if (hazard === 1'b1) haz_cnt++;
        if (ld_decode === 1'b1) pc_log.push_back(pc);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic drive_ready(input bit rnd);
        bit r[4];
        for (int i = 0; i < 4; i++) begin
            if (rnd) r[i] = m_occ[i] ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
            else     r[i] = m_occ[i] && (ages[i] >= dly[i]);
        end
        fetch_ready = r[0]; decode_ready = r[1]; exec_ready = r[2]; wb_ready = r[3];
    endtask

    task automatic drive_dec();
        instr_t ins;
        ins = (n_exec < prog.size()) ? prog[n_exec] : '0;
        dec_rd = ins.rd; dec_rs0 = ins.rs0; dec_rs1 = 4'd0;
        dec_writes = ins.writes; dec_reads = ins.reads;
    endtask

    task automatic step();
        drive_ready(1'b0);
        drive_dec();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        exec_flush = 1'b0; exec_pc = '0;
        prog.delete(); n_exec = 0; haz_cnt = 0; pc_log.delete();
        dly = '{0, 0, 0, 0};
        drive_ready(1'b0);
        drive_dec();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic run_flush(input logic [7:0] target);
        bit hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            drive_ready(1'b0);
            drive_dec();
            if (m_occ[1] && decode_ready && m_occ[2] && exec_ready && !m_occ[3]) begin
                exec_flush = 1'b1;
                exec_pc    = target;
                hit        = 1'b1;
            end
            tick();
            exec_flush = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b0;
        fetch_ready = 0; decode_ready = 0; exec_ready = 0; wb_ready = 0;
        dec_rd = '0; dec_rs0 = '0; dec_rs1 = '0; dec_writes = 0; dec_reads = '0;
        exec_flush = 0; exec_pc = '0;
        last_ld_decode = 0; last_ld_exec = 0;
        @(posedge clk);
        #1;

        // Sequential flow, no dependencies
        do_reset();
        for (int i = 0; i < 20; i++) step();
        for (int k = 0; k < 4; k++)
            check("seq_pc_log", (k < pc_log.size()) ? pc_log[k] : 8'hxx, 8'(2 * k));
        check("seq_no_hazard", 8'(haz_cnt), 8'd0);

        // RAW stall: writer r3, then reader of r3, slow writeback
        do_reset();
        prog.push_back(mk(3, 0, 1'b1, 0));
        prog.push_back(mk(0, 3, 1'b0, 1));
        dly = '{0, 0, 0, 3};
        for (int i = 0; i < 20; i++) step();
        check("raw_stall_cycles", 8'(haz_cnt), 8'd4);
        check("raw_both_issued", 8'(n_exec >= 2), 8'd1);

        // Flush while decode is complete
        do_reset();
        dly = '{0, 0, 2, 0};
        run_flush(8'h40);
        check1("flush_ld_exec", last_ld_exec, 1'b0);
        check("flush_pc", pc, 8'h40);
        check1("flush_wb_en", wb_en, 1'b0);
        check1("flush_fetch_en", fetch_en, 1'b0);
        step();
        check1("refetch_en", fetch_en, 1'b1);
        check("refetch_pc", pc, 8'h40);
        check1("flush_wb_en_later", wb_en, 1'b0);

        // PC wrap at 0xFE
        do_reset();
        dly = '{0, 0, 2, 0};
        run_flush(8'hFE);
        check("wrap_start_pc", pc, 8'hFE);
        last_ld_decode = 1'b0;
        for (int i = 0; i < 10 && !last_ld_decode; i++) step();
        check("wrap_pc", pc, 8'h00);

        // Set/clear collision on r5, observed through a later reader of r5
        do_reset();
        prog.push_back(mk(5, 0, 1'b1, 0));
        prog.push_back(mk(5, 0, 1'b1, 0));
        prog.push_back(mk(0, 5, 1'b0, 1));
        for (int i = 0; i < 16; i++) step();
        check("collision_hazard", 8'(haz_cnt), 8'd1);

        // Asynchronous reset while exec is busy
        do_reset();
        dly = '{0, 0, 4, 0};
        for (int i = 0; i < 20; i++) begin
            drive_ready(1'b0);
            drive_dec();
            if (m_occ[2] && !exec_ready) break;
            tick();
        end
        check1("busy_before_reset", exec_en, 1'b1);
        #1;
        rst = 1'b0;
        #1;
        check("rst_pc", pc, 8'h00);
        check1("rst_fetch_en", fetch_en, 1'b0);
        check1("rst_decode_en", decode_en, 1'b0);
        check1("rst_exec_en", exec_en, 1'b0);
        check1("rst_wb_en", wb_en, 1'b0);
        check1("rst_ld_any", ld_decode | ld_exec | ld_wb, 1'b0);
        check1("rst_hazard", hazard, 1'b0);
        model_reset();
        drive_ready(1'b0);
        tick();
        rst = 1'b1;
        tick();
        check1("post_rst_fetch_en", fetch_en, 1'b1);
        check("post_rst_pc", pc, 8'h00);

        // Random traffic
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            drive_ready(1'b1);
            dec_rd     = 4'($urandom_range(0, 3));
            dec_rs0    = 4'($urandom_range(0, 3));
            dec_rs1    = 4'($urandom_range(0, 3));
            dec_writes = 1'($urandom_range(0, 1));
            dec_reads  = 2'($urandom_range(0, 3));
            exec_flush = ($urandom_range(0, 5) == 0);
            exec_pc    = 8'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
